// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared types and helpers for the pipeline hazard controller.
//   state_e  : controller state encoding (RUN / MEM_WAIT / ERR).
//   hazard_e : hazard classes; the numeric value is the priority rank, so a
//              larger value wins when several hazards are present at once.
//   ctrl_t   : bundle of the four stall and two flush controls.
//   run_hazard() picks the winning hazard while the pipeline is running.
//   ctrl_for()   maps a hazard class to its stall/flush pattern.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_LOADUSE  = 3'd1,
    HZ_REDIRECT = 3'd2,
    HZ_MEMWAIT  = 3'd3,
    HZ_ERR      = 3'd4
  } hazard_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
  } ctrl_t;

  function automatic hazard_e run_hazard(input logic memwait,
                                         input logic redirect,
                                         input logic loaduse);
    hazard_e hz;
    if (memwait)       hz = HZ_MEMWAIT;
    else if (redirect) hz = HZ_REDIRECT;
    else if (loaduse)  hz = HZ_LOADUSE;
    else               hz = HZ_NONE;
    return hz;
  endfunction

  function automatic ctrl_t ctrl_for(input hazard_e hz);
    ctrl_t c;
    c = '0;
    case (hz)
      HZ_ERR, HZ_MEMWAIT: begin
        c.stall_f = 1'b1;
        c.stall_d = 1'b1;
        c.stall_e = 1'b1;
        c.stall_m = 1'b1;
      end
      // A redirect squashes the wrong-path instructions in D and E; any
      // load-use hazard they carry dies with them.
      HZ_REDIRECT: begin
        c.flush_d = 1'b1;
        c.flush_e = 1'b1;
      end
      // Hold F/D and push one bubble into E; next cycle the load has moved
      // to M, so the pair produces exactly one bubble.
      HZ_LOADUSE: begin
        c.stall_f = 1'b1;
        c.stall_d = 1'b1;
        c.flush_e = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- pipeline-to-hazard-controller bundle.
//   i_* : hazard sources from the E/D/M stages and the error-clear strobe.
//   o_* : stage stalls/flushes, sticky memory-timeout flag, statistics.
//   master : the pipeline side (drives i_*, observes o_*).
//   slave  : the controller side.
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             i_LoadE;
  logic [4:0]       i_RdE;
  logic [4:0]       i_Rs1D;
  logic [4:0]       i_Rs2D;
  logic             i_BranchTakenE;
  logic             i_JalE;
  logic             i_JalrE;
  logic             i_MemReqM;
  logic             i_MemAckM;
  logic             i_ErrClr;
  logic             o_StallF;
  logic             o_StallD;
  logic             o_StallE;
  logic             o_StallM;
  logic             o_FlushD;
  logic             o_FlushE;
  logic             o_MemErr;
  logic [CNT_W-1:0] o_StallCnt;
  logic [CNT_W-1:0] o_FlushCnt;

  modport master (
    output i_LoadE, i_RdE, i_Rs1D, i_Rs2D, i_BranchTakenE, i_JalE, i_JalrE,
           i_MemReqM, i_MemAckM, i_ErrClr,
    input  o_StallF, o_StallD, o_StallE, o_StallM, o_FlushD, o_FlushE,
           o_MemErr, o_StallCnt, o_FlushCnt
  );

  modport slave (
    input  i_LoadE, i_RdE, i_Rs1D, i_Rs2D, i_BranchTakenE, i_JalE, i_JalrE,
           i_MemReqM, i_MemAckM, i_ErrClr,
    output o_StallF, o_StallD, o_StallE, o_StallM, o_FlushD, o_FlushE,
           o_MemErr, o_StallCnt, o_FlushCnt
  );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// sat_counter -- event counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge.
//   rst_n : asynchronous active-low reset, clears the count.
//   en_i  : count one event this cycle.
//   cnt_o : current count.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- hazard controller for a 5-stage in-order pipeline.
//   clk   : clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : pipe_ctrl_if slave port; hazard inputs in, stall/flush controls,
//           memory-timeout flag and saturating stall/flush counters out.
// Stall/flush controls are combinational from state and current inputs; the
// state only remembers an outstanding data-memory request and the error.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);
  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              mem_err_q, mem_err_d;
  logic              loaduse, redirect, memwait, ack_valid;
  hazard_e           hz_run, hz;
  ctrl_t             ctrl;

  assign loaduse   = bus.i_LoadE & (bus.i_RdE != 5'd0) &
                     ((bus.i_RdE == bus.i_Rs1D) | (bus.i_RdE == bus.i_Rs2D));
  assign redirect  = bus.i_BranchTakenE | bus.i_JalE | bus.i_JalrE;
  assign memwait   = bus.i_MemReqM & ~bus.i_MemAckM;
  // An ack with no request in M is noise from the memory side.
  assign ack_valid = bus.i_MemReqM & bus.i_MemAckM;
  assign wait_inc  = wait_q + WAIT_W'(1);
  assign hz_run    = run_hazard(memwait, redirect, loaduse);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  // wait_q counts unacknowledged request cycles, including the RUN cycle in
  // which the request first appeared (hence the load of 1).
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_RUN: begin
        if (memwait) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (ack_valid) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_inc >= WAIT_LIMIT) begin
          state_d   = ST_ERR;
          wait_d    = '0;
          mem_err_d = 1'b1;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_ERR: begin
        if (bus.i_ErrClr) begin
          state_d   = ST_RUN;
          mem_err_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // On the ack cycle of MEM_WAIT the stalls release immediately and the
  // E/D hazards are judged exactly as in RUN.
  always_comb begin
    hz = hz_run;
    case (state_q)
      ST_MEM_WAIT: if (!ack_valid) hz = HZ_MEMWAIT;
      ST_ERR:      hz = HZ_ERR;
      default:     ;
    endcase
    // Controls are forced low the moment reset asserts, not at the next edge.
    ctrl = rst_n ? ctrl_for(hz) : '0;
  end

  assign bus.o_StallF = ctrl.stall_f;
  assign bus.o_StallD = ctrl.stall_d;
  assign bus.o_StallE = ctrl.stall_e;
  assign bus.o_StallM = ctrl.stall_m;
  assign bus.o_FlushD = ctrl.flush_d;
  assign bus.o_FlushE = ctrl.flush_e;
  assign bus.o_MemErr = mem_err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ctrl.stall_f),
    .cnt_o (bus.o_StallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (ctrl.flush_e),
    .cnt_o (bus.o_FlushCnt)
  );
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed bench for pipe_ctrl.
// Inputs change 1 ns after the rising edge; outputs are compared on the
// falling edge against a behavioural model that tracks "cycles the current
// memory request has gone unacknowledged" and an error flag. Each stimulus
// vector also carries hand-computed expectations, checked at the same point.
// Narrow counters (CNT_W=4) let the timeout run exercise saturation.
module tb_pipe_ctrl;
  localparam int TO    = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;

  // hand-computed expectations for the current vector (-1 = not checked)
  string lit_name = "none";
  int    lit_ctrl = -1;
  int    lit_sc   = -1;
  int    lit_fc   = -1;
  int    lit_err  = -1;

  // model state
  bit    m_err    = 1'b0;
  int    m_waited = 0;
  int    m_sc     = 0;
  int    m_fc     = 0;

  function automatic logic [5:0] ctrl_now();
    return {bus.o_StallF, bus.o_StallD, bus.o_StallE, bus.o_StallM,
            bus.o_FlushD, bus.o_FlushE};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // compare process
  initial begin
    #3;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        #1;
        chk("reset:ctrl", 32'(ctrl_now()), 32'd0);
        chk("reset:mem_err", 32'(bus.o_MemErr), 32'd0);
        chk("reset:stall_cnt", 32'(bus.o_StallCnt), 32'd0);
        chk("reset:flush_cnt", 32'(bus.o_FlushCnt), 32'd0);
        m_err = 1'b0; m_waited = 0; m_sc = 0; m_fc = 0;
      end else begin
        logic [5:0] exp_c;
        bit         stall_all, redir, lu;
        int         n;
        stall_all = m_err || (bus.i_MemReqM && !bus.i_MemAckM) ||
                    (m_waited > 0 && !(bus.i_MemReqM && bus.i_MemAckM));
        redir = bus.i_BranchTakenE || bus.i_JalE || bus.i_JalrE;
        lu = bus.i_LoadE && (bus.i_RdE != 0) &&
             (bus.i_RdE == bus.i_Rs1D || bus.i_RdE == bus.i_Rs2D);
        if (stall_all)  exp_c = 6'b111100;
        else if (redir) exp_c = 6'b000011;
        else if (lu)    exp_c = 6'b110001;
        else            exp_c = 6'b000000;

        chk("model:ctrl", 32'(ctrl_now()), 32'(exp_c));
        chk("model:mem_err", 32'(bus.o_MemErr), 32'(m_err));
        chk("model:stall_cnt", 32'(bus.o_StallCnt), 32'(m_sc));
        chk("model:flush_cnt", 32'(bus.o_FlushCnt), 32'(m_fc));

        if (lit_ctrl >= 0) chk({lit_name, ":ctrl"}, 32'(ctrl_now()), 32'(lit_ctrl));
        if (lit_sc >= 0)   chk({lit_name, ":stall_cnt"}, 32'(bus.o_StallCnt), 32'(lit_sc));
        if (lit_fc >= 0)   chk({lit_name, ":flush_cnt"}, 32'(bus.o_FlushCnt), 32'(lit_fc));
        if (lit_err >= 0)  chk({lit_name, ":mem_err"}, 32'(bus.o_MemErr), 32'(lit_err));

        // advance the model across the coming rising edge
        if (exp_c[5] && m_sc < CMAX) m_sc++;
        if (exp_c[0] && m_fc < CMAX) m_fc++;
        if (m_err) begin
          if (bus.i_ErrClr) begin
            m_err = 1'b0;
            m_waited = 0;
          end
        end else if (stall_all) begin
          n = m_waited + 1;
          if (n >= TO) begin
            m_err = 1'b1;
            m_waited = 0;
          end else begin
            m_waited = n;
          end
        end else begin
          m_waited = 0;
        end
      end
    end
  end

  task automatic set_inputs(input logic ld, input logic [4:0] rd, rs1, rs2,
                            input logic br, jal, jalr, req, ack, clr);
    bus.i_LoadE        = ld;
    bus.i_RdE          = rd;
    bus.i_Rs1D         = rs1;
    bus.i_Rs2D         = rs2;
    bus.i_BranchTakenE = br;
    bus.i_JalE         = jal;
    bus.i_JalrE        = jalr;
    bus.i_MemReqM      = req;
    bus.i_MemAckM      = ack;
    bus.i_ErrClr       = clr;
  endtask

  task automatic apply(input string nm, input logic ld, input logic [4:0] rd, rs1, rs2,
                       input logic br, jal, jalr, req, ack, clr,
                       input int e_ctrl, e_sc, e_fc, e_err);
    @(posedge clk);
    #1;
    set_inputs(ld, rd, rs1, rs2, br, jal, jalr, req, ack, clr);
    lit_name = nm;
    lit_ctrl = e_ctrl;
    lit_sc   = e_sc;
    lit_fc   = e_fc;
    lit_err  = e_err;
    @(negedge clk);
    #2;
    $display("txn %-14s ctrl=%06b stall_cnt=%0d flush_cnt=%0d mem_err=%0b",
             nm, ctrl_now(), bus.o_StallCnt, bus.o_FlushCnt, bus.o_MemErr);
  endtask

  task automatic idle(input string nm, input int e_sc, e_fc, e_err);
    apply(nm, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, e_sc, e_fc, e_err);
  endtask

  // ctrl encoding {StallF,StallD,StallE,StallM,FlushD,FlushE}:
  // 49 = 110001 load-use, 3 = 000011 redirect, 60 = 111100 full stall
  initial begin
    rst_n = 1'b1;
    // hazardous inputs during reset: controls must still read 0
    set_inputs(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 0, 0);
    #1 rst_n = 1'b0;
    #11;
    set_inputs(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    idle("idle", 0, 0, 0);
    apply("ldu_rs1",    1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0, 49, 0, 0, 0);
    idle("ldu_after", 1, 1, 0);
    apply("ld_x0",      1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, -1);
    apply("ldu_rs2",    1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, 0, 0, 49, 1, 1, -1);
    apply("ld_nomatch", 1, 5'd7, 5'd3, 5'd4, 0, 0, 0, 0, 0, 0, 0, 2, 2, -1);
    apply("br_ldu",     1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, 0, 3, 2, 2, -1);
    apply("jal",        0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 0, 3, 2, 3, -1);
    apply("jalr",       0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 3, 2, 4, -1);
    apply("ack_noreq",  0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 2, 5, -1);
    apply("mem_c1",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 60, 2, 5, 0);
    apply("mem_c2",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 60, 3, 5, 0);
    apply("mem_c3",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 60, 4, 5, 0);
    apply("mem_ack4",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 5, 5, 0);
    idle("after_ack", 5, 5, 0);
    apply("mem_br",     0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 1, 0, 0, 60, 5, 5, 0);
    apply("ack_br_ldu", 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 1, 0, 3, 6, 5, 0);
    idle("after_ack_br", 6, 6, 0);

    for (int i = 1; i <= TO; i++) begin
      apply($sformatf("timeout_%0d", i), 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0,
            60, (5 + i > CMAX) ? CMAX : 5 + i, 6, 0);
    end
    apply("err_hold",   0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 60, 15, 6, 1);
    apply("err_ack",    1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 1, 1, 0, 60, 15, 6, 1);
    apply("err_clr",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 60, 15, 6, 1);
    idle("post_clr", 15, 6, 0);
    apply("post_clr_ldu", 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0, 49, 15, 6, 0);
    idle("fc_check", 15, 7, 0);

    apply("rw1",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 60, 15, 7, 0);
    apply("rw2",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 60, 15, 7, 0);
    // reset pulse between edges while the request is still outstanding
    rst_n = 1'b0;
    #2;
    set_inputs(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle("post_rst", 0, 0, 0);
    apply("post_rst_ldu", 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0, 0, 0, 49, 0, 0, 0);
    idle("final", 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
